alien_fire_scheduler: RTL and testbench

Sequences enemy fire for the playfield. It owns a small pool of alien projectile slots and chooses when the next shot happens, which living alien fires it, and which free slot carries it. It drives each slot's `shoot` request with a handshake and holds the selected alien index stable, so the top level can mux that alien's position onto the slot's launch coordinates. It sits between the alien grid (alive mask) and the array of projectile instances.

---
 rtl/alien_fire_scheduler.sv | 155 +++++++++++++++
 tb/tb_alien_fire_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alien_fire_scheduler.sv
// Enemy fire sequencer: picks a living alien and a free projectile slot,
// then launches it over a shoot/acknowledge handshake.
module alien_fire_scheduler #(
  parameter int          NUM_ALIENS      = 16,
  parameter int          NUM_SLOTS       = 3,
  parameter int          COOLDOWN_FRAMES = 30,
  parameter int          ACK_TIMEOUT     = 4,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          frame_clk,
  input  logic                          game_active,
  input  logic [NUM_ALIENS-1:0]         alien_alive,
  input  logic [NUM_SLOTS-1:0]          slot_busy,
  output logic [NUM_SLOTS-1:0]          shoot,
  output logic [$clog2(NUM_ALIENS)-1:0] fire_alien_idx,
  output logic                          fire_abort
);

  localparam int IW = $clog2(NUM_ALIENS);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [7:0]    CD_BASE  = 8'(COOLDOWN_FRAMES);
  localparam logic [IW-1:0] SCAN_END = IW'(NUM_ALIENS - 1);
  localparam logic [TW-1:0] TICK_END = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    COOLDOWN,
    SCAN,
    SLOT,
    FIRE
  } state_t;

  state_t          state;
  logic            frame_clk_d;
  logic            frame_tick;
  logic [15:0]     lfsr;
  logic [7:0]      cd_cnt;
  logic [IW-1:0]   scan_idx;
  logic [IW-1:0]   scan_cnt;
  logic [TW-1:0]   tick_cnt;

  logic            lfsr_fb;
  logic [7:0]      cd_reload;
  logic            alive_hit;
  logic            scan_last;
  logic            tick_last;
  logic            ack;
  logic [NUM_SLOTS-1:0] free_oh;
  logic            free_any;

  assign lfsr_fb   = lfsr[15] ^ lfsr[13]
                   ^ lfsr[12] ^ lfsr[10];
  assign cd_reload = CD_BASE + {4'd0, lfsr[3:0]};
  assign alive_hit = alien_alive[scan_idx];
  assign scan_last = (scan_cnt == SCAN_END);
  assign tick_last = (tick_cnt == TICK_END);

  // shoot stays one-hot through FIRE, so it doubles as the slot select
  assign ack = |(slot_busy & shoot);

  // isolate the lowest clear bit of slot_busy
  assign free_oh  = ~slot_busy
                  & (slot_busy + NUM_SLOTS'(1));
  assign free_any = |free_oh;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      frame_clk_d    <= 1'b0;
      frame_tick     <= 1'b0;
      lfsr           <= LFSR_SEED;
      state          <= COOLDOWN;
      cd_cnt         <= CD_BASE;
      scan_idx       <= '0;
      scan_cnt       <= '0;
      tick_cnt       <= '0;
      shoot          <= '0;
      fire_alien_idx <= '0;
      fire_abort     <= 1'b0;
    end else begin
      frame_clk_d <= frame_clk;
      frame_tick  <= frame_clk & ~frame_clk_d;
      lfsr        <= {lfsr[14:0], lfsr_fb};
      fire_abort  <= 1'b0;

      if (!game_active) begin
        state  <= COOLDOWN;
        shoot  <= '0;
        cd_cnt <= CD_BASE;
      end else begin
        unique case (state)
          COOLDOWN: begin
            if (frame_tick) begin
              if (cd_cnt == 8'd0) begin
                state    <= SCAN;
                scan_idx <= lfsr[IW-1:0];
                scan_cnt <= '0;
              end else begin
                cd_cnt <= cd_cnt - 8'd1;
              end
            end
          end

          SCAN: begin
            if (alive_hit) begin
              fire_alien_idx <= scan_idx;
              state          <= SLOT;
            end else if (scan_last) begin
              cd_cnt <= cd_reload;
              state  <= COOLDOWN;
            end else begin
              scan_idx <= scan_idx + IW'(1);
              scan_cnt <= scan_cnt + IW'(1);
            end
          end

          SLOT: begin
            if (free_any) begin
              shoot    <= free_oh;
              tick_cnt <= '0;
              state    <= FIRE;
            end else begin
              cd_cnt <= cd_reload;
              state  <= COOLDOWN;
            end
          end

          FIRE: begin
            if (ack) begin
              shoot  <= '0;
              cd_cnt <= cd_reload;
              state  <= COOLDOWN;
            end else if (frame_tick) begin
              if (tick_last) begin
                fire_abort <= 1'b1;
                shoot      <= '0;
                cd_cnt     <= cd_reload;
                state      <= COOLDOWN;
              end else begin
                tick_cnt <= tick_cnt + TW'(1);
              end
            end
          end

          default: begin
            shoot <= '0;
            state <= COOLDOWN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alien_fire_scheduler.sv
// Directed bench for alien_fire_scheduler: table of fire scenarios
// plus hand sequences for mid-fire disable and reset.
module tb_alien_fire_scheduler;

  localparam int NA = 16;
  localparam int CD = 30;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_clk = 1'b0;
  logic        game_active = 1'b0;
  logic [15:0] alien_alive = '0;
  logic [2:0]  slot_busy = '0;
  logic [2:0]  shoot;
  logic [3:0]  fire_alien_idx;
  logic        fire_abort;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_lfsr;
  logic [15:0] last_lfsr;
  int          jit;
  int          exp_last_idx;

  typedef struct {
    logic [15:0] alive;
    logic [2:0]  busy;
    logic [2:0]  exp_shoot;
    int          exp_idx;
    bit          ack;
  } vec_t;

  vec_t vecs[6];

  alien_fire_scheduler dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .frame_clk      (frame_clk),
    .game_active    (game_active),
    .alien_alive    (alien_alive),
    .slot_busy      (slot_busy),
    .shoot          (shoot),
    .fire_alien_idx (fire_alien_idx),
    .fire_abort     (fire_abort)
  );

  always #5 Clk = ~Clk;

  // reference LFSR: taps 16,14,13,11, seeded on reset
  always @(posedge Clk) begin
    if (!Reset_n) m_lfsr <= 16'hACE1;
    else m_lfsr <= {m_lfsr[14:0],
                    m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one frame_clk pulse; returns one edge after the FSM consumes the tick
  task automatic tick();
    frame_clk = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b0;
    last_lfsr = m_lfsr;
    @(negedge Clk);
  endtask

  task automatic try_fire(input logic [2:0] exp_shoot, input int exp_idx);
    int  start;
    int  d;
    int  target;
    bit  found;
    tick();
    start = int'(last_lfsr[3:0]);
    found = 1'b0;
    d = 0;
    for (int i = 0; i < NA; i++) begin
      if (!found && alien_alive[(start + i) % NA]) begin
        found = 1'b1;
        d = i;
      end
    end
    target = found ? 4 + d : 2 + NA;
    for (int i = 2; i <= target; i++) begin
      if (i == target - 1) jit = int'(m_lfsr[3:0]);
      chk("abort_idle", 32'(fire_abort), 32'd0);
      if (i < target) begin
        chk("shoot_early", 32'(shoot), 32'd0);
        @(negedge Clk);
      end else begin
        chk("shoot_launch", 32'(shoot),
            found ? 32'(exp_shoot) : 32'd0);
      end
    end
    if (found && exp_shoot != 3'b000) begin
      exp_last_idx = (exp_idx < 0) ? (start + d) % NA : exp_idx;
      chk("fire_idx", 32'(fire_alien_idx), 32'(exp_last_idx));
    end
  endtask

  task automatic cool(input int n, input logic [2:0] exp_shoot,
                      input int exp_idx);
    for (int t = 1; t < n; t++) begin
      tick();
      chk("cooldown_quiet", 32'({fire_abort, shoot}), 32'd0);
    end
    try_fire(exp_shoot, exp_idx);
  endtask

  task automatic ack_seq(input logic [2:0] s);
    for (int c = 1; c <= 5; c++) begin
      @(negedge Clk);
      chk("ack_hold", 32'(shoot), 32'(s));
    end
    slot_busy = slot_busy | s;
    jit = int'(m_lfsr[3:0]);
    @(negedge Clk);
    chk("ack_release", 32'({fire_abort, shoot}), 32'd0);
  endtask

  task automatic timeout_seq(input logic [2:0] s);
    for (int t = 1; t <= 3; t++) begin
      tick();
      chk("timeout_wait", 32'({fire_abort, shoot}), 32'({1'b0, s}));
    end
    tick();
    jit = int'(last_lfsr[3:0]);
    chk("timeout_abort", 32'({fire_abort, shoot}), 32'h8);
    @(negedge Clk);
    chk("abort_pulse_len", 32'(fire_abort), 32'd0);
  endtask

  initial begin
    vecs[0] = '{16'hFFFF, 3'b000, 3'b001, -1, 1'b1};
    vecs[1] = '{16'h0100, 3'b001, 3'b010,  8, 1'b1};
    vecs[2] = '{16'h0100, 3'b111, 3'b000,  8, 1'b0};
    vecs[3] = '{16'h0003, 3'b011, 3'b100, -1, 1'b1};
    vecs[4] = '{16'h0000, 3'b000, 3'b000, -1, 1'b0};
    vecs[5] = '{16'h0100, 3'b000, 3'b001,  8, 1'b0};

    repeat (3) begin
      @(negedge Clk);
      chk("reset_vals",
          32'({fire_abort, fire_alien_idx, shoot}), 32'd0);
    end
    Reset_n = 1'b1;
    game_active = 1'b1;
    jit = 0;

    for (int v = 0; v < 6; v++) begin
      alien_alive = vecs[v].alive;
      slot_busy = vecs[v].busy;
      cool(CD + jit + 1, vecs[v].exp_shoot, vecs[v].exp_idx);
      if (vecs[v].exp_shoot != 3'b000) begin
        if (vecs[v].ack) ack_seq(vecs[v].exp_shoot);
        else timeout_seq(vecs[v].exp_shoot);
      end
    end

    // disable while firing: shoot drops, index held, cooldown unjittered
    alien_alive = 16'hFFFF;
    slot_busy = 3'b000;
    cool(CD + jit + 1, 3'b001, -1);
    game_active = 1'b0;
    @(negedge Clk);
    chk("disable_shoot", 32'({fire_abort, shoot}), 32'd0);
    chk("disable_idx_hold", 32'(fire_alien_idx), 32'(exp_last_idx));
    @(negedge Clk);
    game_active = 1'b1;
    jit = 0;
    cool(CD + 1, 3'b001, -1);

    // reset while firing clears outputs on the same edge
    Reset_n = 1'b0;
    @(negedge Clk);
    chk("reset_midfire",
        32'({fire_abort, fire_alien_idx, shoot}), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    jit = 0;
    cool(CD + 1, 3'b001, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
